// File: rtl/llr_pe_array.sv
`default_nettype none
// ============================================================================
// Module   : llr_pe_array
// Brief    : LANES-wide pipelined f/g LLR update with symmetric saturation,
//            valid/ready flow control and an output beat counter.
// Revision : 1.0 - initial release
// ============================================================================
module llr_pe_array #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int PIPE       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] a_in,
    input  logic [LANES*DATA_WIDTH-1:0] b_in,
    input  logic [LANES-1:0]            us_in,
    input  logic                        sel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] llr_out,
    output logic [LANES-1:0]            sat_flag,
    output logic [15:0]                 beat_cnt
);

    localparam logic signed [DATA_WIDTH-1:0] c_max     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] c_min     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] c_neg_max = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [DATA_WIDTH:0]   c_max_x     = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0]   c_neg_max_x = {2'b11, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    logic [LANES*DATA_WIDTH-1:0] w_res;
    logic [LANES-1:0]            w_sat;

    // Results are computed ahead of stage 0, so sel/us travel with the beat.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] w_a, w_b, w_a_c, w_b_c;
        logic signed [DATA_WIDTH-1:0] w_mag_a, w_mag_b, w_min, w_f, w_g;
        logic signed [DATA_WIDTH:0]   w_sum;
        logic                         w_clamp_a, w_clamp_b, w_ovf;

        assign w_a       = a_in[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_b       = b_in[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_clamp_a = (w_a == c_min);
        assign w_clamp_b = (w_b == c_min);
        assign w_a_c     = w_clamp_a ? c_neg_max : w_a;
        assign w_b_c     = w_clamp_b ? c_neg_max : w_b;

        assign w_mag_a = w_a_c[DATA_WIDTH-1] ? -w_a_c : w_a_c;
        assign w_mag_b = w_b_c[DATA_WIDTH-1] ? -w_b_c : w_b_c;
        assign w_min   = (w_mag_a < w_mag_b) ? w_mag_a : w_mag_b;
        assign w_f     = (w_a_c[DATA_WIDTH-1] ^ w_b_c[DATA_WIDTH-1]) ? -w_min : w_min;

        assign w_sum = us_in[k] ? ({w_b_c[DATA_WIDTH-1], w_b_c} - {w_a_c[DATA_WIDTH-1], w_a_c})
                                : ({w_b_c[DATA_WIDTH-1], w_b_c} + {w_a_c[DATA_WIDTH-1], w_a_c});
        assign w_ovf = (w_sum > c_max_x) || (w_sum < c_neg_max_x);
        assign w_g   = (w_sum > c_max_x)     ? c_max :
                       (w_sum < c_neg_max_x) ? c_neg_max : w_sum[DATA_WIDTH-1:0];

        assign w_res[k*DATA_WIDTH +: DATA_WIDTH] = sel ? w_f : w_g;
        assign w_sat[k] = w_clamp_a | w_clamp_b | (~sel & w_ovf);
    end

    logic [PIPE-1:0]             r_vld;
    logic [LANES*DATA_WIDTH-1:0] r_data [PIPE];
    logic [LANES-1:0]            r_sat  [PIPE];
    logic [PIPE-1:0]             w_load;
    logic [15:0]                 r_cnt;
    logic                        w_out_xfer;

    // A stage loads unless it and every stage downstream is full and stalled.
    for (genvar i = 0; i < PIPE; i++) begin : g_load
        assign w_load[i] = !(&r_vld[PIPE-1:i]) || out_ready;
    end

    assign in_ready   = w_load[0] && !rst;
    assign out_valid  = r_vld[PIPE-1] && !rst;
    assign llr_out    = rst ? '0 : r_data[PIPE-1];
    assign sat_flag   = rst ? '0 : r_sat[PIPE-1];
    assign beat_cnt   = rst ? '0 : r_cnt;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_cnt <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_data[i] <= '0;
                r_sat[i]  <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= w_res;
                    r_sat[0]  <= w_sat;
                end
            end
            // Payload only moves with a valid beat, so bubbles never carry idle data.
            for (int i = 1; i < PIPE; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_data[i] <= r_data[i-1];
                        r_sat[i]  <= r_sat[i-1];
                    end
                end
            end
            if (w_out_xfer) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_llr_pe_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_llr_pe_array
// Brief    : Self-checking bench for llr_pe_array (default, narrow and wide builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_llr_pe_array;

    localparam int DW = 8,  L = 4,  P = 2;
    localparam int DW2 = 16, L2 = 4, P2 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0, sel = 1'b0, out_ready = 1'b1;
    logic              in_ready, out_valid;
    logic [L*DW-1:0]   a_in = '0, b_in = '0, llr_out;
    logic [L-1:0]      us_in = '0, sat_flag;
    logic [15:0]       beat_cnt;

    logic              iv1 = 1'b0, sel1 = 1'b0, or1 = 1'b1, ir1, ov1;
    logic [7:0]        a1 = '0, b1 = '0, llr1;
    logic [0:0]        us1 = '0, sat1;
    logic [15:0]       cnt1;

    logic              iv2 = 1'b0, sel2 = 1'b0, or2 = 1'b1, ir2, ov2;
    logic [L2*DW2-1:0] a2 = '0, b2 = '0, llr2;
    logic [L2-1:0]     us2 = '0, sat2;
    logic [15:0]       cnt2;

    llr_pe_array #(.DATA_WIDTH(DW), .LANES(L), .PIPE(P)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .us_in(us_in), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .llr_out(llr_out), .sat_flag(sat_flag), .beat_cnt(beat_cnt));

    llr_pe_array #(.DATA_WIDTH(8), .LANES(1), .PIPE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a_in(a1), .b_in(b1), .us_in(us1), .sel(sel1),
        .out_valid(ov1), .out_ready(or1),
        .llr_out(llr1), .sat_flag(sat1), .beat_cnt(cnt1));

    llr_pe_array #(.DATA_WIDTH(DW2), .LANES(L2), .PIPE(P2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a_in(a2), .b_in(b2), .us_in(us2), .sel(sel2),
        .out_valid(ov2), .out_ready(or2),
        .llr_out(llr2), .sat_flag(sat2), .beat_cnt(cnt2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [15:0] v, input int dw);
        int x;
        x = int'(v) & ((1 << dw) - 1);
        if (x >= (1 << (dw - 1))) x -= (1 << dw);
        return x;
    endfunction

    // Reference behaviour in plain integer arithmetic.
    function automatic void model(input int dw, input int a, input int b, input bit us,
                                  input bit s, output int r, output bit sat);
        int mx, aa, bb, ma, mb, t;
        mx = (1 << (dw - 1)) - 1;
        sat = 1'b0;
        aa = a;
        bb = b;
        if (aa == -mx - 1) begin aa = -mx; sat = 1'b1; end
        if (bb == -mx - 1) begin bb = -mx; sat = 1'b1; end
        if (s) begin
            ma = (aa < 0) ? -aa : aa;
            mb = (bb < 0) ? -bb : bb;
            t  = (ma < mb) ? ma : mb;
            r  = ((aa < 0) != (bb < 0)) ? -t : t;
        end else begin
            t = us ? (bb - aa) : (bb + aa);
            if (t > mx) begin t = mx; sat = 1'b1; end
            else if (t < -mx) begin t = -mx; sat = 1'b1; end
            r = t;
        end
    endfunction

    typedef struct {
        logic [L*DW-1:0] d;
        logic [L-1:0]    s;
    } exp_t;

    exp_t q[$];
    exp_t held;
    bit   stalled = 1'b0;
    int   run = 0;
    int   max_run = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        int   r;
        bit   s;
        if (rst) begin
            q.delete();
            stalled = 1'b0;
            run = 0;
        end else begin
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_llr", llr_out, held.d);
                chk("hold_sat", sat_flag, held.s);
            end
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held.d = llr_out;
                held.s = sat_flag;
            end
            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (out_valid && out_ready) begin
                chk("sb_nonempty", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_llr", llr_out, e.d);
                    chk("sb_sat", sat_flag, e.s);
                end
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < L; k++) begin
                    model(DW, sx(16'(a_in[k*DW +: DW]), DW), sx(16'(b_in[k*DW +: DW]), DW),
                          us_in[k], sel, r, s);
                    e.d[k*DW +: DW] = r[DW-1:0];
                    e.s[k] = s;
                end
                q.push_back(e);
            end
        end
    end

    typedef struct {
        int         a [L];
        int         b [L];
        bit [L-1:0] us;
        bit         s;
        int         e [L];
        bit [L-1:0] es;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [DW-1:0] rnd();
        if ($urandom_range(0, 5) == 0) return {1'b1, {(DW-1){1'b0}}};
        return DW'($urandom);
    endfunction

    task automatic drive_rand(input int mode, input int idx);
        for (int k = 0; k < L; k++) begin
            a_in[k*DW +: DW] = rnd();
            b_in[k*DW +: DW] = rnd();
        end
        us_in = L'($urandom);
        sel   = (mode == 1) ? (idx % 2 == 0) : 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_timeout", int'(t < 50), 1);
    endtask

    task automatic stream(input int n, input int stall_at, input int stall_len,
                          input int mode, output bit saw_low);
        int sent = 0;
        int cyc = 0;
        bit acc;
        bit fresh = 1'b1;
        saw_low = 1'b0;
        while (sent < n && cyc < n + stall_len + 50) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid  = 1'b1;
            if (fresh) drive_rand(mode, sent);
            @(negedge clk);
            acc = in_ready;
            if (!acc) saw_low = 1'b1;
            @(posedge clk); #1;
            if (acc) sent++;
            fresh = acc;
            cyc++;
        end
        chk("stream_sent", sent, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_llr", llr_out, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_cnt", beat_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_cnt", beat_cnt, 0);
        @(posedge clk); #1;
    endtask

    task automatic apply_vec(input int i);
        int lat = 0;
        for (int k = 0; k < L; k++) begin
            a_in[k*DW +: DW] = DW'(tbl[i].a[k]);
            b_in[k*DW +: DW] = DW'(tbl[i].b[k]);
        end
        us_in = tbl[i].us;
        sel = tbl[i].s;
        in_valid = 1'b1;
        @(negedge clk);
        chk("vec_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 12);
        chk("vec_latency", lat, P);
        for (int k = 0; k < L; k++) begin
            chk("vec_llr", sx(16'(llr_out[k*DW +: DW]), DW), tbl[i].e[k]);
        end
        chk("vec_sat", sat_flag, tbl[i].es);
        @(posedge clk); #1;
    endtask

    task automatic beat1(input int a, input int b, input bit us, input bit s);
        int r;
        bit sb;
        int lat = 0;
        model(8, a, b, us, s, r, sb);
        a1 = 8'(a);
        b1 = 8'(b);
        us1 = us;
        sel1 = s;
        iv1 = 1'b1;
        @(negedge clk);
        chk("d1_in_ready", ir1, 1);
        @(posedge clk); #1;
        iv1 = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov1 && lat < 12);
        chk("d1_latency", lat, 1);
        chk("d1_llr", sx(16'(llr1), 8), r);
        chk("d1_sat", sat1, sb);
        @(posedge clk); #1;
    endtask

    task automatic beat2(input int a [L2], input int b [L2], input bit [L2-1:0] us,
                         input bit s, input int e3, input bit es3);
        int r;
        bit sb;
        int lat = 0;
        for (int k = 0; k < L2; k++) begin
            a2[k*DW2 +: DW2] = DW2'(a[k]);
            b2[k*DW2 +: DW2] = DW2'(b[k]);
        end
        us2 = us;
        sel2 = s;
        iv2 = 1'b1;
        @(negedge clk);
        chk("d2_in_ready", ir2, 1);
        @(posedge clk); #1;
        iv2 = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov2 && lat < 12);
        chk("d2_latency", lat, P2);
        for (int k = 0; k < L2; k++) begin
            model(DW2, a[k], b[k], us[k], s, r, sb);
            chk("d2_llr", sx(llr2[k*DW2 +: DW2], DW2), r);
            chk("d2_sat", sat2[k], sb);
        end
        chk("d2_top_lane_llr", sx(llr2[(L2-1)*DW2 +: DW2], DW2), e3);
        chk("d2_top_lane_sat", sat2[L2-1], es3);
        @(posedge clk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit saw_low;
        int va [L2];
        int vb [L2];

        tbl[0].a = '{-5, -128, 0, 127};   tbl[0].b = '{3, -100, -7, -128};
        tbl[0].us = 4'b0000; tbl[0].s = 1'b1;
        tbl[0].e = '{-3, 100, 0, -127};   tbl[0].es = 4'b1010;
        tbl[1].a = '{100, -100, 100, 20}; tbl[1].b = '{100, 100, -100, -7};
        tbl[1].us = 4'b1010; tbl[1].s = 1'b0;
        tbl[1].e = '{127, 127, 0, -27};   tbl[1].es = 4'b0011;
        tbl[2].a = '{-128, -128, -100, 5}; tbl[2].b = '{0, 0, -100, -3};
        tbl[2].us = 4'b0010; tbl[2].s = 1'b0;
        tbl[2].e = '{-127, 127, -127, 2}; tbl[2].es = 4'b0111;
        tbl[3].a = '{0, -1, 64, -128};    tbl[3].b = '{0, -1, -65, -128};
        tbl[3].us = 4'b1111; tbl[3].s = 1'b1;
        tbl[3].e = '{0, 1, -64, 127};     tbl[3].es = 4'b1000;

        do_reset();
        for (int i = 0; i < 4; i++) apply_vec(i);

        // Alternating f/g stream without bubbles.
        do_reset();
        max_run = 0;
        stream(8, 1000, 0, 1, saw_low);
        chk("mixed_consecutive", int'(max_run >= 8), 1);
        chk("mixed_cnt", beat_cnt, 8);

        do_reset();
        stream(10, 4, 3, 0, saw_low);
        chk("bp_in_ready_dropped", saw_low, 1);
        chk("bp_cnt", beat_cnt, 10);

        // Two beats in flight discarded by a one-cycle reset.
        do_reset();
        in_valid = 1'b1;
        drive_rand(0, 0);
        @(posedge clk); #1;
        drive_rand(0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < P + 3; c++) begin
            @(negedge clk);
            chk("post_rst_out_valid", out_valid, 0);
            chk("post_rst_cnt", beat_cnt, 0);
        end
        @(posedge clk); #1;
        apply_vec(0);
        chk("post_rst_cnt_one", beat_cnt, 1);

        do_reset();
        stream(65535, 1000000, 0, 0, saw_low);
        chk("wrap_pre", beat_cnt, 16'hFFFF);
        stream(1, 1000000, 0, 0, saw_low);
        chk("wrap_post", beat_cnt, 0);

        beat1(-5, 3, 1'b0, 1'b1);
        beat1(-128, -100, 1'b0, 1'b1);
        beat1(100, 100, 1'b0, 1'b0);
        beat1(-100, 100, 1'b1, 1'b0);
        beat1(20, -7, 1'b1, 1'b0);
        chk("d1_cnt", cnt1, 5);

        va = '{-5, -32768, 0, -32768};  vb = '{3, -100, 7, -32768};
        beat2(va, vb, 4'b0000, 1'b1, 32767, 1'b1);
        va = '{100, -100, 20, 30000};   vb = '{100, 100, -7, 30000};
        beat2(va, vb, 4'b0110, 1'b0, 32767, 1'b1);
        va = '{-32768, 5, 32767, 20};   vb = '{0, -32768, -32767, -7};
        beat2(va, vb, 4'b1000, 1'b0, -27, 1'b0);
        chk("d2_cnt", cnt2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
